// File: rtl/boot_sequencer.sv
// Boot engine: optional data-memory init from a data ROM, then the INSTR/REG/BAR/PC/NULL packet
// stream that hands the core off to run. Data-memory init is built only with BOOT_DMEM_INIT_EN.
//   net_packet_flat_o = {reserved[0], id[9:0], net_op[2:0], net_data[31:0], net_addr[9:0]}
//   mem_flat_o        = {valid, yumi, wen, byte_not_word, write_data[31:0]}
module boot_sequencer #(
    parameter int unsigned INSTR_WORDS = 1024,
    parameter int unsigned REG_WORDS   = 64,
    parameter int unsigned DATA_WORDS  = 1024,
    parameter logic [9:0]  CORE_ID     = 10'd1,
    parameter logic [31:0] BAR_MASK    = 32'h2,
    parameter logic [31:0] START_PC    = 32'h5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    output logic [9:0]  instr_addr_o,
    input  logic [15:0] instr_data_i,
    output logic [5:0]  reg_addr_o,
    input  logic [39:0] reg_data_i,
    output logic [9:0]  data_addr_o,
    input  logic [31:0] data_data_i,
    output logic [35:0] mem_flat_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_select_o,
    output logic [55:0] net_packet_flat_o,
    output logic        net_valid_o,
    input  logic        net_ready_i,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [2:0] OpNull  = 3'd0;
    localparam logic [2:0] OpInstr = 3'd1;
    localparam logic [2:0] OpReg   = 3'd2;
    localparam logic [2:0] OpPc    = 3'd3;
    localparam logic [2:0] OpBar   = 3'd4;

    localparam logic [9:0] InstrLast = 10'(INSTR_WORDS - 1);
    localparam logic [9:0] RegLast   = 10'(REG_WORDS - 1);
    localparam logic [9:0] DataLast  = 10'(DATA_WORDS - 1);

    typedef enum logic [3:0] {
        StIdle, StDmem, StDgap, StInstr, StReg, StBar, StPc, StHandoff, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [9:0]  idx_q, idx_d;            // next element to request in the current phase
    logic        null_req_q, null_req_d;
    // Fetch slot: one element whose ROM word is on the ROM data bus.
    logic        f_vld_q, f_vld_d;
    logic [2:0]  f_op_q, f_op_d;
    logic [9:0]  f_idx_q, f_idx_d;
    logic [9:0]  instr_addr_q, instr_addr_d;
    logic [5:0]  reg_addr_q, reg_addr_d;
    logic [55:0] pkt_q, pkt_d;
    logic        valid_q, valid_d;

    logic        accept, out_free, f_take, f_free, req, phase_last;
    logic [2:0]  req_op;
    logic [31:0] pk_data;
    logic [9:0]  pk_addr;

    logic        unused_reg;
    assign unused_reg = ^reg_data_i[39:38];

`ifdef BOOT_DMEM_INIT_EN
    logic [9:0]  d_idx_q, d_idx_d;
    logic        d_ph_q, d_ph_d;          // DMEM: ROM word ready; DGAP: gap cycle done
    logic [35:0] mem_flat_q, mem_flat_d;
    logic [31:0] mem_addr_q, mem_addr_d;
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        null_req_d   = null_req_q;
        f_vld_d      = f_vld_q;
        f_op_d       = f_op_q;
        f_idx_d      = f_idx_q;
        instr_addr_d = instr_addr_q;
        reg_addr_d   = reg_addr_q;
        pkt_d        = pkt_q;
        valid_d      = valid_q;
`ifdef BOOT_DMEM_INIT_EN
        d_idx_d      = d_idx_q;
        d_ph_d       = d_ph_q;
        mem_flat_d   = '0;
        mem_addr_d   = mem_addr_q;
`endif

        accept   = valid_q & net_ready_i;
        out_free = ~valid_q | net_ready_i;
        f_take   = f_vld_q & out_free;
        f_free   = ~f_vld_q | f_take;

        req        = 1'b0;
        req_op     = OpNull;
        phase_last = 1'b1;
        case (state_q)
            StInstr: begin
                req        = f_free;
                req_op     = OpInstr;
                phase_last = (idx_q == InstrLast);
            end
            StReg: begin
                req        = f_free;
                req_op     = OpReg;
                phase_last = (idx_q == RegLast);
            end
            StBar: begin
                req    = f_free;
                req_op = OpBar;
            end
            StPc: begin
                req    = f_free;
                req_op = OpPc;
            end
            StHandoff: begin
                req    = f_free & ~null_req_q;
                req_op = OpNull;
            end
            default: ;
        endcase

        pk_data = 32'hFFFF_FFFE;
        pk_addr = 10'd24;
        case (f_op_q)
            OpInstr: begin
                pk_data = {16'b0, instr_data_i};
                pk_addr = f_idx_q;
            end
            OpReg: begin
                pk_data = reg_data_i[31:0];
                pk_addr = {4'b0, reg_data_i[37:32]};
            end
            OpBar: begin
                pk_data = BAR_MASK;
                pk_addr = 10'd24;
            end
            OpPc: begin
                pk_data = START_PC;
                pk_addr = 10'd0;
            end
            default: ;
        endcase

        // Packet register keeps its last contents once emptied, so DONE shows the NULL packet.
        if (f_take) begin
            valid_d = 1'b1;
            pkt_d   = {1'b0, CORE_ID, f_op_q, pk_data, pk_addr};
        end else if (accept) begin
            valid_d = 1'b0;
        end

        if (req) begin
            f_vld_d = 1'b1;
            f_op_d  = req_op;
            f_idx_d = idx_q;
        end else if (f_take) begin
            f_vld_d = 1'b0;
        end

        // ROM addresses move only when the fetch slot is refilled, so they hold under stall.
        if (req && state_q == StInstr) instr_addr_d = idx_q;
        if (req && state_q == StReg)   reg_addr_d   = idx_q[5:0];

        case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
`ifdef BOOT_DMEM_INIT_EN
                    state_d = StDmem;
                    d_idx_d = '0;
                    d_ph_d  = 1'b0;
`else
                    state_d = StInstr;
`endif
                    idx_d      = '0;
                    null_req_d = 1'b0;
                end
            end
`ifdef BOOT_DMEM_INIT_EN
            StDmem: begin
                if (!d_ph_q) begin
                    d_ph_d = 1'b1;
                end else begin
                    mem_flat_d = {4'b1110, data_data_i};
                    mem_addr_d = {20'b0, d_idx_q, 2'b00};
                    d_ph_d     = 1'b0;
                    if (d_idx_q == DataLast) state_d = StDgap;
                    else                     d_idx_d = d_idx_q + 10'd1;
                end
            end
            StDgap: begin
                if (!d_ph_q) begin
                    d_ph_d = 1'b1;
                end else begin
                    state_d = StInstr;
                    idx_d   = '0;
                end
            end
`endif
            StInstr: begin
                if (req) begin
                    if (phase_last) begin
                        state_d = StReg;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 10'd1;
                    end
                end
            end
            StReg: begin
                if (req) begin
                    if (phase_last) begin
                        state_d = StBar;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 10'd1;
                    end
                end
            end
            StBar: if (req) state_d = StPc;
            StPc:  if (req) state_d = StHandoff;
            StHandoff: begin
                if (req) begin
                    null_req_d = 1'b1;
                end else if (null_req_q && !f_vld_q && accept) begin
                    state_d = StDone;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            null_req_q   <= 1'b0;
            f_vld_q      <= 1'b0;
            f_op_q       <= OpNull;
            f_idx_q      <= '0;
            instr_addr_q <= '0;
            reg_addr_q   <= '0;
            pkt_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            null_req_q   <= null_req_d;
            f_vld_q      <= f_vld_d;
            f_op_q       <= f_op_d;
            f_idx_q      <= f_idx_d;
            instr_addr_q <= instr_addr_d;
            reg_addr_q   <= reg_addr_d;
            pkt_q        <= pkt_d;
            valid_q      <= valid_d;
        end
    end

`ifdef BOOT_DMEM_INIT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_idx_q    <= '0;
            d_ph_q     <= 1'b0;
            mem_flat_q <= '0;
            mem_addr_q <= '0;
        end else begin
            d_idx_q    <= d_idx_d;
            d_ph_q     <= d_ph_d;
            mem_flat_q <= mem_flat_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign data_addr_o  = d_idx_q;
    assign mem_flat_o   = mem_flat_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_select_o = ~(state_q == StDmem || state_q == StDgap);
`else
    logic unused_data;
    assign unused_data  = ^{data_data_i, DataLast};

    assign data_addr_o  = '0;
    assign mem_flat_o   = '0;
    assign mem_addr_o   = '0;
    assign mem_select_o = 1'b1;
`endif

    // Combinational next address: the ROM registers exactly what the fetch slot will hold.
    assign instr_addr_o      = instr_addr_d;
    assign reg_addr_o        = reg_addr_d;
    assign net_packet_flat_o = pkt_q;
    assign net_valid_o       = valid_q;
    assign busy_o            = ~(state_q == StIdle || state_q == StDone);
    assign done_o            = (state_q == StDone);

endmodule

// File: doc/boot_sequencer.md
# boot_sequencer

Hardware boot engine upstream of the core's network port and data memory. It replaces the bench-driven bring-up sequence with synthesizable logic. On `start_i` it:
- initializes data memory from a data image ROM;
- streams one INSTR packet per instruction-ROM word and one REG packet per register-ROM entry;
- issues the fixed BAR, PC and NULL packets that hand the core off to run.

Its outputs feed the core's flattened `net_packet_s` input and, through `mem_select_o`, the data-memory port mux.

## Interface
Parameters:
- `INSTR_WORDS`, 1024: instruction ROM depth; INSTR packets sent.
- `REG_WORDS`, 64 (`2**rs_imm_size_gp`): register ROM depth; REG packets sent.
- `DATA_WORDS`, 1024: data ROM depth; words stored.
- `CORE_ID`, 10'd1: `ID` field of every packet.
- `BAR_MASK`, 32'h2: `net_data` of BAR packet.
- `START_PC`, 32'h5: `net_data` of PC packet.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `start_i` in 1: begin sequence; sampled only in IDLE.
- `instr_addr_o` out 10: instruction ROM address.
- `instr_data_i` in 16: {opcode, rd, rs_imm}; 1-cycle synchronous read latency.
- `reg_addr_o` out 6: register ROM address.
- `reg_data_i` in 40: [37:32] register number, [31:0] value; 1-cycle latency.
- `data_addr_o` out 10: data ROM address.
- `data_data_i` in 32: data word; 1-cycle latency.
- `mem_flat_o` out `$bits(mem_in_s)`: store port to data memory.
- `mem_addr_o` out 32: byte address for store.
- `mem_select_o` out 1: 0 = boot owns data memory, 1 = core owns it.
- `net_packet_flat_o` out `$bits(net_packet_s)`: packet to core.
- `net_valid_o` out 1: packet valid.
- `net_ready_i` in 1: packet accepted on `net_valid_o && net_ready_i`.
- `busy_o` out 1: sequence in progress.
- `done_o` out 1: sticky; sequence complete.

## Operation
- States: IDLE, DMEM, DGAP, INSTR, REG, BAR, PC, HANDOFF, DONE.
- IDLE → DMEM on `start_i`. Goes to INSTR instead when DMEM is compiled out.
- DMEM:
  - Word i is read from data ROM address i.
  - Stored with `valid=1, yumi=1, wen=1, byte_not_word=0`, `write_data`=word, `mem_addr_o`=i*4.
  - Store strobes last one cycle each, exactly 2 cycles apart; `valid=0` between strobes.
- DGAP: one cycle after the last strobe with `valid=0`; `mem_select_o` rises on exit to INSTR.
- INSTR packets:
  - `ID=CORE_ID`, `net_op=INSTR`, `reserved=0`.
  - `net_data={16'b0, instr_data_i}`, `net_addr=i`.
  - i runs 0..INSTR_WORDS-1.
- REG packets:
  - `net_op=REG`, `net_data=reg_data_i[31:0]`, `net_addr={4'b0, reg_data_i[37:32]}`.
  - i runs 0..REG_WORDS-1.
- BAR packet: `net_op=BAR`, `net_data=BAR_MASK`, `net_addr=24`.
- PC packet: `net_op=PC`, `net_data=START_PC`, `net_addr=0`.
- HANDOFF packet: `net_op=NULL`, `net_data=32'hFFFFFFFE`, `net_addr=24`. On acceptance → DONE.
- DONE:
  - `done_o=1`, `busy_o=0`, `net_valid_o=0`.
  - Packet register holds the NULL packet.
  - `start_i` in DONE restarts (→ DMEM/INSTR) and clears `done_o`.
- Backpressure:
  - While `net_valid_o && !net_ready_i`, the packet and the ROM addresses hold stable.
  - The ROM index advances only on acceptance.
- Index counters are exact-width with compare-to-last; there is no wrap. Phase changes occur on acceptance of the last element.

## Timing
- Reset values:
  - `net_valid_o=0`, `net_packet_flat_o=0` (NULL op), `mem_flat_o=0`.
  - `mem_addr_o=0`, all ROM addresses 0.
  - `mem_select_o=1`, `busy_o=0`, `done_o=0`, state IDLE.
- `reset` mid-sequence: immediate return to IDLE and reset values; no partial packet is held.
- Start latency:
  - First store strobe is 2 cycles after the `start_i` sample edge.
  - First INSTR packet is valid 2 cycles after INSTR entry (ROM latency plus output register).
- Throughput with `net_ready_i` held high: one packet per cycle, including across phase boundaries.
- `busy_o` is high from the cycle after `start_i` through the cycle HANDOFF is accepted.
- `mem_select_o` is 0 only during DMEM and DGAP.
- `start_i` while busy is ignored.

## Configuration
- `BOOT_DMEM_INIT_EN` defined: DMEM and DGAP phases are present as above.
- Undefined:
  - DMEM/DGAP logic and the data ROM port are removed.
  - `data_addr_o=0`, `mem_flat_o=0`, `mem_select_o` constant 1.
  - IDLE goes directly to INSTR.

## Test plan
- Params 4/4/4, DMEM enabled, ready high, ROM data {A0,A1,A2,A3}:
  - Stores at addr 0,4,8,12 on cycles +2,+4,+6,+8.
  - `mem_select_o` rises at +10.
  - 11 contiguous packets follow; `done_o` rises after the NULL packet.
- INSTR ROM word 16'h0841 at index 2 → packet `net_op=INSTR`, `net_data=32'h0000_0841`, `net_addr=2`.
- REG ROM entry 40'h05_DEADBEEF → REG packet `net_addr=5`, `net_data=32'hDEADBEEF`. Then BAR (2, 24), PC (5, 0), NULL (FFFFFFFE, 24), in order.
- `net_ready_i` low for 3 cycles mid-INSTR → packet bits and `instr_addr_o` unchanged for 3 cycles; no packet dropped or duplicated.
- `reset` pulsed during REG phase → all outputs at reset values; a new `start_i` replays the full sequence from index 0.
- `BOOT_DMEM_INIT_EN` undefined → no store strobes; first INSTR packet valid 2 cycles after `start_i`.
